// File: rtl/note_box_tracker.sv
// Note slot table with a pixel hit-test pipeline and a strike/consume engine.
// A small IDLE/CLEAR controller sweeps all slots disabled one per cycle.
module note_box_tracker #(
  parameter int NUM_NOTES = 8,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int SZ_W      = 7,
  parameter int HIT_TOP   = 400,
  parameter int HIT_BOT   = 440,
  localparam int IW       = $clog2(NUM_NOTES)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [IW-1:0]   load_idx,
  input  logic [X_W-1:0]  load_x,
  input  logic [Y_W-1:0]  load_y,
  input  logic [SZ_W-1:0] load_w,
  input  logic [SZ_W-1:0] load_h,
  input  logic            load_en,
  input  logic            clear_all,
  input  logic            pix_valid,
  input  logic [X_W-1:0]  curr_x,
  input  logic [Y_W-1:0]  curr_y,
  output logic            in_valid,
  output logic            in_any,
  output logic [IW-1:0]   in_idx,
  input  logic            strike,
  output logic            hit_valid,
  output logic [IW-1:0]   hit_idx,
  output logic            miss,
  output logic [15:0]     hit_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [Y_W:0] HIT_TOP_E = (Y_W+1)'(HIT_TOP);
  localparam logic [Y_W:0] HIT_BOT_E = (Y_W+1)'(HIT_BOT);

  logic [X_W-1:0]  x_q [NUM_NOTES];
  logic [X_W-1:0]  x_d [NUM_NOTES];
  logic [Y_W-1:0]  y_q [NUM_NOTES];
  logic [Y_W-1:0]  y_d [NUM_NOTES];
  logic [SZ_W-1:0] w_q [NUM_NOTES];
  logic [SZ_W-1:0] w_d [NUM_NOTES];
  logic [SZ_W-1:0] h_q [NUM_NOTES];
  logic [SZ_W-1:0] h_d [NUM_NOTES];
  logic [NUM_NOTES-1:0] en_q, en_d;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;

  logic [NUM_NOTES-1:0] match_vec, zone_vec;
  logic [NUM_NOTES-1:0] match_q, match_d;
  logic            pv1_q, pv1_d;
  logic            in_valid_q, in_valid_d;
  logic            in_any_q, in_any_d;
  logic [IW-1:0]   in_idx_q, in_idx_d;

  logic            hit_valid_q, hit_valid_d;
  logic            miss_q, miss_d;
  logic [IW-1:0]   hit_idx_q, hit_idx_d;
  logic [15:0]     hit_count_q, hit_count_d;

  logic            load_fire, strike_ok;

  function automatic logic [IW-1:0] lowest_set(input logic [NUM_NOTES-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Far edges are one bit wider so notes hanging off-screen never wrap to 0.
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_slot
    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;
    assign x_end = (X_W+1)'(x_q[g]) + (X_W+1)'(w_q[g]);
    assign y_end = (Y_W+1)'(y_q[g]) + (Y_W+1)'(h_q[g]);
    assign match_vec[g] = en_q[g]
                          && (curr_x > x_q[g]) && ((X_W+1)'(curr_x) < x_end)
                          && (curr_y > y_q[g]) && ((Y_W+1)'(curr_y) < y_end);
    assign zone_vec[g]  = en_q[g] && (y_end > HIT_TOP_E)
                          && ((Y_W+1)'(y_q[g]) < HIT_BOT_E);
  end

  assign load_ready = resetn && (state_q == ST_IDLE);
  assign load_fire  = load_valid && load_ready;
  assign strike_ok  = strike && (state_q == ST_IDLE) && !clear_all;

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    en_d        = en_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_valid_d = 1'b0;
    miss_d      = 1'b0;
    hit_idx_d   = '0;
    hit_count_d = hit_count_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        en_d[cnt_q] = 1'b0;
        if (cnt_q == IW'(NUM_NOTES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (strike_ok) begin
      if (|zone_vec) begin
        hit_valid_d        = 1'b1;
        hit_idx_d          = lowest_set(zone_vec);
        en_d[hit_idx_d]    = 1'b0;
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        miss_d = 1'b1;
      end
    end

    // A load lands after the consume so it wins on a shared slot.
    if (load_fire) begin
      x_d[load_idx]  = load_x;
      y_d[load_idx]  = load_y;
      w_d[load_idx]  = load_w;
      h_d[load_idx]  = load_h;
      en_d[load_idx] = load_en;
    end
  end

  always_comb begin
    match_d    = match_vec;
    pv1_d      = pix_valid;
    in_valid_d = pv1_q;
    in_any_d   = pv1_q && (|match_q);
    in_idx_d   = in_any_d ? lowest_set(match_q) : '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        w_q[i] <= '0;
        h_q[i] <= '0;
      end
      en_q        <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      match_q     <= '0;
      pv1_q       <= 1'b0;
      in_valid_q  <= 1'b0;
      in_any_q    <= 1'b0;
      in_idx_q    <= '0;
      hit_valid_q <= 1'b0;
      miss_q      <= 1'b0;
      hit_idx_q   <= '0;
      hit_count_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      en_q        <= en_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      pv1_q       <= pv1_d;
      in_valid_q  <= in_valid_d;
      in_any_q    <= in_any_d;
      in_idx_q    <= in_idx_d;
      hit_valid_q <= hit_valid_d;
      miss_q      <= miss_d;
      hit_idx_q   <= hit_idx_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign in_valid  = in_valid_q;
  assign in_any    = in_any_q;
  assign in_idx    = in_idx_q;
  assign hit_valid = hit_valid_q;
  assign miss      = miss_q;
  assign hit_idx   = hit_idx_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_note_box_tracker.sv
// Directed, table-driven bench for note_box_tracker: pixel edges, priority,
// wrap, strikes, clear sweep and asynchronous reset.
module tb_note_box_tracker;

  logic        clock;
  logic        resetn;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  load_idx;
  logic [9:0]  load_x;
  logic [8:0]  load_y;
  logic [6:0]  load_w;
  logic [6:0]  load_h;
  logic        load_en;
  logic        clear_all;
  logic        pix_valid;
  logic [9:0]  curr_x;
  logic [8:0]  curr_y;
  logic        in_valid;
  logic        in_any;
  logic [2:0]  in_idx;
  logic        strike;
  logic        hit_valid;
  logic [2:0]  hit_idx;
  logic        miss;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

  note_box_tracker dut (
    .clock(clock), .resetn(resetn),
    .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_w(load_w), .load_h(load_h),
    .load_en(load_en), .clear_all(clear_all),
    .pix_valid(pix_valid), .curr_x(curr_x), .curr_y(curr_y),
    .in_valid(in_valid), .in_any(in_any), .in_idx(in_idx),
    .strike(strike), .hit_valid(hit_valid), .hit_idx(hit_idx), .miss(miss),
    .hit_count(hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [8:0] y;
    logic       v;
    logic       any;
    logic [2:0] idx;
  } pix_vec_t;

  pix_vec_t vecs[9];

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_slot(input int idx, input int x, input int y, input int w,
                           input int h, input logic en);
    load_valid = 1'b1;
    load_idx   = 3'(idx);
    load_x     = 10'(x);
    load_y     = 9'(y);
    load_w     = 7'(w);
    load_h     = 7'(h);
    load_en    = en;
    tick();
    load_valid = 1'b0;
  endtask

  // Issues one pixel, checks nothing emerges after one edge and the result after two.
  task automatic apply_pixel(input string name, input logic [9:0] x, input logic [8:0] y,
                             input logic v, input logic any, input logic [2:0] idx);
    pix_valid = v;
    curr_x    = x;
    curr_y    = y;
    tick();
    pix_valid = 1'b0;
    check_val({name, " lat1 in_valid"}, int'(in_valid), 0);
    tick();
    check_val({name, " in_valid"}, int'(in_valid), int'(v));
    check_val({name, " in_any"}, int'(in_any), int'(any));
    check_val({name, " in_idx"}, int'(in_idx), int'(idx));
  endtask

  task automatic do_strike(input string name, input logic exp_hit, input int exp_idx,
                           input int exp_count);
    strike = 1'b1;
    tick();
    strike = 1'b0;
    check_val({name, " hit_valid"}, int'(hit_valid), int'(exp_hit));
    check_val({name, " miss"}, int'(miss), int'(!exp_hit));
    check_val({name, " hit_idx"}, int'(hit_idx), exp_idx);
    check_val({name, " hit_count"}, int'(hit_count), exp_count);
  endtask

  initial begin
    int n;
    logic pulse;

    vecs[0] = '{"edge_in_tl",   10'd101,  9'd51,  1'b1, 1'b1, 3'd0};
    vecs[1] = '{"edge_left",    10'd100,  9'd51,  1'b1, 1'b0, 3'd0};
    vecs[2] = '{"edge_right",   10'd120,  9'd55,  1'b1, 1'b0, 3'd0};
    vecs[3] = '{"edge_in_br",   10'd119,  9'd59,  1'b1, 1'b1, 3'd0};
    vecs[4] = '{"edge_bottom",  10'd110,  9'd60,  1'b1, 1'b0, 3'd0};
    vecs[5] = '{"overlap",      10'd200,  9'd200, 1'b1, 1'b1, 3'd3};
    vecs[6] = '{"wrap",         10'd5,    9'd10,  1'b1, 1'b0, 3'd0};
    vecs[7] = '{"wrap_inside",  10'd1021, 9'd50,  1'b1, 1'b1, 3'd1};
    vecs[8] = '{"no_valid",     10'd101,  9'd51,  1'b0, 1'b0, 3'd0};

    resetn = 1'b1; load_valid = 1'b0; load_idx = '0; load_x = '0; load_y = '0;
    load_w = '0; load_h = '0; load_en = 1'b0; clear_all = 1'b0; pix_valid = 1'b0;
    curr_x = '0; curr_y = '0; strike = 1'b0;

    #1 resetn = 1'b0;
    #2;
    check_val("rst load_ready", int'(load_ready), 0);
    check_val("rst in_valid", int'(in_valid), 0);
    check_val("rst hit_count", int'(hit_count), 0);
    #19 resetn = 1'b1;
    #1;
    check_val("post-rst load_ready", int'(load_ready), 1);

    load_slot(0, 100, 50, 20, 10, 1'b1);
    load_slot(1, 1020, 0, 10, 100, 1'b1);
    load_slot(3, 190, 190, 20, 20, 1'b1);
    load_slot(5, 195, 195, 10, 10, 1'b1);
    for (int i = 0; i < 9; i++)
      apply_pixel(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].any, vecs[i].idx);

    load_slot(3, 190, 190, 20, 20, 1'b0);
    apply_pixel("overlap_dis3", 10'd200, 9'd200, 1'b1, 1'b1, 3'd5);

    load_slot(2, 0, 395, 5, 10, 1'b1);
    do_strike("strike1", 1'b1, 2, 1);
    do_strike("strike2", 1'b0, 0, 1);
    tick();
    check_val("pulse gone hit", int'(hit_valid), 0);
    check_val("pulse gone miss", int'(miss), 0);

    // Back-to-back strikes: the second must see the first consume.
    load_slot(4, 0, 420, 5, 5, 1'b1);
    load_slot(6, 0, 420, 5, 5, 1'b1);
    strike = 1'b1;
    tick();
    check_val("b2b first idx", int'(hit_idx), 4);
    check_val("b2b first hit", int'(hit_valid), 1);
    tick();
    strike = 1'b0;
    check_val("b2b second idx", int'(hit_idx), 6);
    check_val("b2b second count", int'(hit_count), 3);

    // Load and consume on the same slot: load keeps it enabled.
    load_slot(7, 0, 410, 5, 5, 1'b1);
    load_valid = 1'b1; load_idx = 3'd7; load_x = 10'd0; load_y = 9'd410;
    load_w = 7'd5; load_h = 7'd5; load_en = 1'b1;
    do_strike("load_vs_hit", 1'b1, 7, 4);
    load_valid = 1'b0;
    do_strike("load_won", 1'b1, 7, 5);

    // Clear sweep, with a strike on the clear_all cycle and another mid-sweep.
    clear_all = 1'b1;
    strike    = 1'b1;
    tick();
    clear_all = 1'b0;
    strike    = 1'b0;
    check_val("clr same-cycle hit", int'(hit_valid), 0);
    check_val("clr same-cycle miss", int'(miss), 0);
    n = 0;
    pulse = 1'b0;
    while (!load_ready && n < 20) begin
      strike = (n == 2);
      pulse  = pulse | hit_valid | miss;
      n++;
      tick();
    end
    strike = 1'b0;
    pulse  = pulse | hit_valid | miss;
    check_val("clear ready-low cycles", n, 8);
    check_val("clear strike pulse", int'(pulse), 0);
    check_val("clear hit_count", int'(hit_count), 5);
    apply_pixel("after_clear_pix", 10'd101, 9'd51, 1'b1, 1'b0, 3'd0);
    do_strike("after_clear_strike", 1'b0, 0, 5);

    // Reset in the middle of a sweep with a pixel in flight.
    load_slot(0, 100, 50, 20, 10, 1'b1);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    tick();
    tick();
    pix_valid = 1'b1; curr_x = 10'd101; curr_y = 9'd51;
    tick();
    pix_valid = 1'b0;
    check_val("mid-clear ready", int'(load_ready), 0);
    resetn = 1'b0;
    #1;
    check_val("async rst load_ready", int'(load_ready), 0);
    check_val("async rst in_valid", int'(in_valid), 0);
    check_val("async rst in_any", int'(in_any), 0);
    check_val("async rst hit_count", int'(hit_count), 0);
    check_val("async rst miss", int'(miss), 0);
    @(posedge clock);
    #3 resetn = 1'b1;
    #1;
    check_val("rst2 load_ready", int'(load_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst2 no stale in_valid", int'(in_valid), 0);
      check_val("rst2 no stale hit", int'(hit_valid), 0);
    end
    apply_pixel("rst2_pix", 10'd101, 9'd51, 1'b1, 1'b0, 3'd0);
    do_strike("rst2_strike", 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
